tile_fetch_arbiter: RTL and testbench

TILE_FETCH_ARBITER -- requirements
Module: tile_fetch_arbiter

---
 rtl/tile_pkg.sv | 10 +
 rtl/tile_fetch_arbiter_if.sv | 13 +
 rtl/tile_fetch_arbiter_rr_pick.sv | 15 +
 rtl/tile_fetch_arbiter.sv | 76 +++++++
 tb/tb_tile_fetch_arbiter.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/tile_pkg.sv
// tile_pkg: shared tile ROM geometry, requester indices and arbiter state encoding.
package tile_pkg;
  localparam int TILE_DEPTH   = 1786;
  localparam int ADDR_W       = 11;
  localparam int DATA_W       = 4;
  localparam int REQ_PLATFORM = 0;
  localparam int REQ_PLAYER   = 1;
  localparam int REQ_ENEMY    = 2;
  typedef enum logic {ARB, LOCKED} arb_state_e;
endpackage

// File: rtl/tile_fetch_arbiter_if.sv
// tile_fetch_arbiter_if: requester request/grant, tile ROM and response signals of the fetch arbiter.
interface tile_fetch_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = tile_pkg::ADDR_W,
  parameter int DATA_W  = tile_pkg::DATA_W
);
  logic [NUM_REQ-1:0]        req, lock, gnt, rsp_valid, err;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data, rsp_data;
  modport master (output req, lock, addr, rom_data, input gnt, rom_addr, rsp_valid, rsp_data, err);
  modport slave  (input req, lock, addr, rom_data, output gnt, rom_addr, rsp_valid, rsp_data, err);
endinterface

// File: rtl/tile_fetch_arbiter_rr_pick.sv
// rr_pick: one-hot round-robin pick, first asserted req at or above ptr (wrapping) wins.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  always_comb begin
    gnt = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) gnt = N'(1) << ((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/tile_fetch_arbiter.sv
// tile_fetch_arbiter: round-robin tile ROM arbiter with burst locking and 2-cycle responses.
// Optional out-of-range address trapping when TILE_ARB_RANGE_CHECK_EN is defined.
module tile_fetch_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = tile_pkg::ADDR_W,
  parameter int DATA_W     = tile_pkg::DATA_W,
  parameter int TILE_DEPTH = tile_pkg::TILE_DEPTH,
  parameter int MAX_BURST  = 16
) (
  input logic                Clk,
  input logic                Reset_n,
  tile_fetch_arbiter_if.slave bus
);
  import tile_pkg::*;
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int BW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
`ifdef TILE_ARB_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif
  arb_state_e         state_q, state_d;
  logic [PW-1:0]      p_q, p_d, owner_q, owner_d, idx;
  logic [BW-1:0]      burst_q, burst_d, cnt;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d, addr_sel;
  logic [NUM_REQ-1:0] tag1_q, tag2_q, err1_q, err1_d, err2_q, rr_gnt, gnt;
  logic               owner_hold, oor;
  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (.req(bus.req), .ptr(p_q), .gnt(rr_gnt));
  always_comb begin
    owner_hold = state_q == LOCKED && bus.req[owner_q] && bus.lock[owner_q];
    gnt        = owner_hold ? NUM_REQ'(1) << owner_q : rr_gnt;
    idx        = '0;
    addr_sel   = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) begin
        idx      = PW'(i);
        addr_sel = bus.addr[i*ADDR_W +: ADDR_W];
      end
    cnt        = owner_hold ? burst_q : '0;
    oor        = RANGE_CHECK && 32'(addr_sel) >= 32'(TILE_DEPTH);
    p_d        = |gnt ? (idx == PW'(NUM_REQ - 1) ? '0 : idx + 1'b1) : p_q;
    owner_d    = |gnt ? idx : owner_q;
    rom_addr_d = |gnt ? (oor ? '0 : addr_sel) : rom_addr_q;
    err1_d     = oor ? gnt : '0;
    // The final allowed grant of a burst drops back to ARB so the pointer moves on.
    state_d    = |gnt && bus.lock[idx] && cnt != BW'(MAX_BURST - 1) ? LOCKED : ARB;
    burst_d    = state_d == LOCKED ? cnt + 1'b1 : '0;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q    <= ARB;
      p_q        <= '0;
      owner_q    <= '0;
      burst_q    <= '0;
      rom_addr_q <= '0;
      tag1_q     <= '0;
      tag2_q     <= '0;
      err1_q     <= '0;
      err2_q     <= '0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      owner_q    <= owner_d;
      burst_q    <= burst_d;
      rom_addr_q <= rom_addr_d;
      tag1_q     <= gnt;
      tag2_q     <= tag1_q;
      err1_q     <= err1_d;
      err2_q     <= err1_q;
    end
  assign bus.gnt       = gnt;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rsp_valid = tag2_q;
  assign bus.err       = err2_q;
  assign bus.rsp_data  = |err2_q ? '0 : bus.rom_data;
endmodule

// File: tb/tb_tile_fetch_arbiter.sv
// tb_tile_fetch_arbiter: directed checks of rotation, latency, burst lock, range trap and reset flush.
module tb_tile_fetch_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  tile_fetch_arbiter_if bus ();
  tile_fetch_arbiter dut (.Clk(clk), .Reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [3:0] rom_word(input logic [10:0] a);
    return 4'(a + 11'd14);
  endfunction
  always_ff @(posedge clk) bus.rom_data <= rom_word(bus.rom_addr);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [2:0] r, input logic [2:0] l);
    bus.req  = r;
    bus.lock = l;
    @(negedge clk);
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.lock = '0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 0);
    chk("rst_err", 32'(bus.err), 0);
    nxt();
    rst_n = 1'b1;
  endtask
  function automatic logic [10:0] a_of(input logic [2:0] g);
    return g[0] ? 11'd10 : g[1] ? 11'd20 : 11'd30;
  endfunction
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [2:0] exp_g [6];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    bus.addr = {11'd30, 11'd20, 11'd10};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(3'b111, 3'b000);
      chk("rr_gnt", 32'(bus.gnt), 32'(exp_g[c]));
      if (c >= 1) chk("rr_rom_addr", 32'(bus.rom_addr), 32'(a_of(exp_g[c-1])));
      chk("rr_rsp_valid", 32'(bus.rsp_valid), c >= 2 ? 32'(exp_g[c-2]) : 0);
      if (c >= 2) chk("rr_rsp_data", 32'(bus.rsp_data), 32'(rom_word(a_of(exp_g[c-2]))));
      nxt();
    end
    for (int c = 0; c < 3; c++) begin
      drive(3'b000, 3'b000);
      chk("idle_gnt", 32'(bus.gnt), 0);
      chk("idle_rom_addr", 32'(bus.rom_addr), 30);
      chk("idle_rsp_valid", 32'(bus.rsp_valid), c == 0 ? 32'b010 : c == 1 ? 32'b100 : 0);
      nxt();
    end
    bus.addr = {11'd30, 11'd5, 11'd10};
    drive(3'b010, 3'b000);
    chk("lat_gnt", 32'(bus.gnt), 32'b010);
    nxt();
    drive(3'b000, 3'b000);
    chk("lat_rom_addr", 32'(bus.rom_addr), 5);
    chk("lat_rsp_early", 32'(bus.rsp_valid), 0);
    nxt();
    drive(3'b000, 3'b000);
    chk("lat_rsp_valid", 32'(bus.rsp_valid), 32'b010);
    chk("lat_rsp_data", 32'(bus.rsp_data), 3);
    chk("lat_err", 32'(bus.err), 0);
    nxt();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(3'b111, 3'b001);
      chk($sformatf("burst_gnt%0d", k), 32'(bus.gnt), 32'b001);
      nxt();
    end
    drive(3'b111, 3'b001);
    chk("burst_release", 32'(bus.gnt), 32'b010);
    nxt();
    drive(3'b111, 3'b001);
    chk("burst_after2", 32'(bus.gnt), 32'b100);
    nxt();
    drive(3'b111, 3'b001);
    chk("burst_relock", 32'(bus.gnt), 32'b001);
    nxt();
    drive(3'b111, 3'b000);
    chk("lock_drop", 32'(bus.gnt), 32'b010);
    nxt();
    bus.addr = {11'd1786, 11'd20, 11'd10};
    drive(3'b100, 3'b000);
    chk("oor_gnt", 32'(bus.gnt), 32'b100);
    nxt();
    drive(3'b000, 3'b000);
`ifdef TILE_ARB_RANGE_CHECK_EN
    chk("oor_rom_addr", 32'(bus.rom_addr), 0);
`else
    chk("oor_rom_addr", 32'(bus.rom_addr), 1786);
`endif
    nxt();
    drive(3'b000, 3'b000);
    chk("oor_rsp_valid", 32'(bus.rsp_valid), 32'b100);
`ifdef TILE_ARB_RANGE_CHECK_EN
    chk("oor_rsp_data", 32'(bus.rsp_data), 0);
    chk("oor_err", 32'(bus.err), 32'b100);
`else
    chk("oor_rsp_data", 32'(bus.rsp_data), 8);
    chk("oor_err", 32'(bus.err), 0);
`endif
    nxt();
    bus.addr = {11'd30, 11'd20, 11'd10};
    do_reset();
    drive(3'b111, 3'b000);
    chk("mid_gnt0", 32'(bus.gnt), 32'b001);
    nxt();
    drive(3'b111, 3'b000);
    chk("mid_gnt1", 32'(bus.gnt), 32'b010);
    #1;
    rst_n   = 1'b0;
    bus.req = '0;
    #1;
    chk("mid_rst_rsp", 32'(bus.rsp_valid), 0);
    chk("mid_rst_rom_addr", 32'(bus.rom_addr), 0);
    repeat (2) begin
      @(negedge clk);
      chk("mid_hold_rsp", 32'(bus.rsp_valid), 0);
    end
    nxt();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(3'b000, 3'b000);
      chk("mid_after_rsp", 32'(bus.rsp_valid), 0);
      nxt();
    end
    drive(3'b111, 3'b000);
    chk("mid_first_gnt", 32'(bus.gnt), 32'b001);
    nxt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
